// File: rtl/wb_regfile_ctrl.sv
// Writeback stage and architectural register file for the LC-3 pipeline.
// Commits the WB instruction's result, provides two bypassed read ports, and
// sequences interrupt entry (stack swap, PSR push, PC push, acknowledge).
module wb_regfile_ctrl #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       SP_IDX   = 6,
  parameter int unsigned       LINK_IDX = 7,
  parameter int unsigned       SP_STEP  = 2,
  parameter logic [DATA_W-1:0] SSP_INIT = DATA_W'(16'h3000)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pause,
  input  logic                           irq,
  input  logic                           user_mode,
  input  logic                           wb_valid,
  input  logic [15:0]                    wb_ir,
  input  logic [DATA_W-1:0]              wb_npc,
  input  logic [DATA_W-1:0]              wb_data,
  input  logic [ADDR_W-1:0]              rd_addr_a,
  input  logic [ADDR_W-1:0]              rd_addr_b,
  output logic [DATA_W-1:0]              rd_data_a,
  output logic [DATA_W-1:0]              rd_data_b,
  output logic [DATA_W*(2**ADDR_W)-1:0]  regs_flat,
  output logic                           wb_intf,
  output logic                           wb_exc,
  output logic                           wb_stall,
  output logic                           push_valid,
  output logic [DATA_W-1:0]              push_addr,
  output logic                           push_sel,
  output logic                           int_ack
);

  localparam int unsigned       NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_PUSH_PSR,
    S_PUSH_PC,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   ssp_q, ssp_d;
  logic [DATA_W-1:0]   usp_q, usp_d;
  logic                intf_q, intf_d;
  logic                exc_q, exc_d;

  logic                irq_take;
  logic                commit;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                is_rti;
  logic                is_exc;
  logic [ADDR_W-1:0]   dr;
  logic [DATA_W-1:0]   sp_dec;
  logic                ir_unused;

  assign ir_unused = ^wb_ir[8:6];
  assign dr        = ADDR_W'(wb_ir[11:9]);
  assign sp_dec    = regs_q[SP_A] - DATA_W'(SP_STEP);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the whole sequence freezes while paused
  always_comb begin
    state_d = state_q;
    if (!pause) begin
      case (state_q)
        S_IDLE:     if (irq) state_d = S_SWAP;
        S_SWAP:     state_d = S_PUSH_PSR;
        S_PUSH_PSR: state_d = S_PUSH_PC;
        S_PUSH_PC:  state_d = S_ACK;
        S_ACK:      state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and commit qualification; irq wins over a commit in IDLE
  always_comb begin
    irq_take   = (state_q == S_IDLE) && !pause && irq;
    commit     = (state_q == S_IDLE) && !pause && !irq && wb_valid;
    wb_stall   = (state_q != S_IDLE) || irq_take;
    push_valid = !pause && ((state_q == S_PUSH_PSR) || (state_q == S_PUSH_PC));
    push_sel   = (state_q == S_PUSH_PC);
    push_addr  = push_valid ? sp_dec : '0;
    int_ack    = !pause && (state_q == S_ACK);
  end

  // Instruction decode: single register write per commit
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = dr;
    wr_data = wb_data;
    is_rti  = 1'b0;
    is_exc  = 1'b0;
    case (wb_ir[15:12])
      4'b0001, 4'b0101, 4'b0010, 4'b0110, 4'b1010, 4'b1110: wr_en = 1'b1;
      4'b1001: wr_en = (wb_ir[5:0] != 6'b100010);
      4'b0100, 4'b1111: begin
        wr_en   = 1'b1;
        wr_addr = LINK_A;
        wr_data = wb_npc;
      end
      // RTI back to user mode: the usp restore supersedes the wb_data write
      4'b1000: begin
        is_rti  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = SP_A;
        wr_data = user_mode ? usp_q : wb_data;
      end
      4'b1101: is_exc = 1'b1;
      default: wr_en = 1'b0;
    endcase
  end

  // Register file, saved stack pointers and pulse next-values
  always_comb begin
    regs_d = regs_q;
    ssp_d  = ssp_q;
    usp_d  = usp_q;
    intf_d = commit && is_rti;
    exc_d  = commit && is_exc;
    if (commit && wr_en) regs_d[wr_addr] = wr_data;
    if (commit && is_rti && user_mode) ssp_d = wb_data;
    if (!pause) begin
      case (state_q)
        S_SWAP: begin
          if (user_mode) begin
            usp_d        = regs_q[SP_A];
            regs_d[SP_A] = ssp_q;
          end
        end
        S_PUSH_PSR, S_PUSH_PC: regs_d[SP_A] = sp_dec;
        default: ;
      endcase
    end
  end

  // Datapath flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ssp_q  <= SSP_INIT;
      usp_q  <= '0;
      intf_q <= 1'b0;
      exc_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ssp_q  <= ssp_d;
      usp_q  <= usp_d;
      intf_q <= intf_d;
      exc_q  <= exc_d;
    end
  end

  assign wb_intf = intf_q;
  assign wb_exc  = exc_q;

  // Read ports with bypass of the commit landing this cycle
  always_comb begin
    rd_data_a = (commit && wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
    rd_data_b = (commit && wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
  end

  // Flattened register view, R0 in the LSBs
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: tb/tb_wb_regfile_ctrl.sv
// Scoreboard bench for wb_regfile_ctrl: stimulus pushes expected per-cycle
// responses from a reference model; a monitor on the falling edge compares.
module tb_wb_regfile_ctrl;

  logic         clk;
  logic         reset;
  logic         pause;
  logic         irq;
  logic         user_mode;
  logic         wb_valid;
  logic [15:0]  wb_ir;
  logic [15:0]  wb_npc;
  logic [15:0]  wb_data;
  logic [2:0]   rd_addr_a;
  logic [2:0]   rd_addr_b;
  logic [15:0]  rd_data_a;
  logic [15:0]  rd_data_b;
  logic [127:0] regs_flat;
  logic         wb_intf;
  logic         wb_exc;
  logic         wb_stall;
  logic         push_valid;
  logic [15:0]  push_addr;
  logic         push_sel;
  logic         int_ack;

  wb_regfile_ctrl #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .SP_IDX   (6),
    .LINK_IDX (7),
    .SP_STEP  (2),
    .SSP_INIT (16'h3000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .irq        (irq),
    .user_mode  (user_mode),
    .wb_valid   (wb_valid),
    .wb_ir      (wb_ir),
    .wb_npc     (wb_npc),
    .wb_data    (wb_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .regs_flat  (regs_flat),
    .wb_intf    (wb_intf),
    .wb_exc     (wb_exc),
    .wb_stall   (wb_stall),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .push_sel   (push_sel),
    .int_ack    (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  rd_a;
    logic [15:0]  rd_b;
    logic [127:0] regs;
    logic         stall;
    logic         pv;
    logic         ack;
    logic         intf;
    logic         exc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        sel;
  } push_t;

  exp_t  sb[$];
  push_t push_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural registers, saved SPs, pending pulses
  // and the list of remaining interrupt-entry steps (1 swap, 2 push PSR,
  // 3 push PC, 4 acknowledge).
  logic [15:0] m_r [8];
  logic [15:0] m_ssp;
  logic [15:0] m_usp;
  logic        m_intf;
  logic        m_exc;
  int          script[$];

  // Staged stimulus, applied just after each rising edge
  logic        s_rst, s_pause, s_irq, s_um, s_valid;
  logic [15:0] s_ir, s_npc, s_data;
  logic [2:0]  s_ra, s_rb;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What the committed instruction writes, straight from the opcode table
  task automatic decode(output logic we, output logic [2:0] wa, output logic [15:0] wd,
                        output logic rti, output logic exc);
    we  = 1'b0;
    wa  = wb_ir[11:9];
    wd  = wb_data;
    rti = 1'b0;
    exc = 1'b0;
    case (wb_ir[15:12])
      4'd1, 4'd5, 4'd2, 4'd6, 4'd10, 4'd14: we = 1'b1;
      4'd9:  we = (wb_ir[5:0] != 6'h22);
      4'd4, 4'd15: begin we = 1'b1; wa = 3'd7; wd = wb_npc; end
      4'd8:  begin rti = 1'b1; we = 1'b1; wa = 3'd6; wd = user_mode ? m_usp : wb_data; end
      4'd13: exc = 1'b1;
      default: we = 1'b0;
    endcase
  endtask

  task automatic model_cycle();
    exp_t        e;
    push_t       p;
    logic        busy, take, cmt, we, rti, exc;
    logic [2:0]  wa;
    logic [15:0] wd;
    int          step;
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_ssp  = 16'h3000;
      m_usp  = 16'h0;
      m_intf = 1'b0;
      m_exc  = 1'b0;
      script.delete();
    end
    busy = (script.size() != 0);
    step = busy ? script[0] : 0;
    take = !busy && !pause && irq;
    cmt  = !busy && !pause && !irq && wb_valid;
    decode(we, wa, wd, rti, exc);
    e.rd_a  = (cmt && we && wa == rd_addr_a) ? wd : m_r[rd_addr_a];
    e.rd_b  = (cmt && we && wa == rd_addr_b) ? wd : m_r[rd_addr_b];
    for (int i = 0; i < 8; i++) e.regs[i*16 +: 16] = m_r[i];
    e.stall = busy || take;
    e.pv    = busy && !pause && (step == 2 || step == 3);
    e.ack   = busy && !pause && (step == 4);
    e.intf  = m_intf;
    e.exc   = m_exc;
    sb.push_back(e);
    if (e.pv) begin
      p.addr = m_r[6] - 16'd2;
      p.sel  = (step == 3);
      push_q.push_back(p);
    end
    if (reset) begin
      m_intf = cmt && rti;
      m_exc  = cmt && exc;
      if (cmt && we) m_r[wa] = wd;
      if (cmt && rti && user_mode) m_ssp = wb_data;
      if (busy && !pause) begin
        if (step == 1 && user_mode) begin
          m_usp  = m_r[6];
          m_r[6] = m_ssp;
        end
        if (step == 2 || step == 3) m_r[6] = m_r[6] - 16'd2;
        void'(script.pop_front());
      end
      if (take) begin
        script.push_back(1);
        script.push_back(2);
        script.push_back(3);
        script.push_back(4);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    reset     = s_rst;
    pause     = s_pause;
    irq       = s_irq;
    user_mode = s_um;
    wb_valid  = s_valid;
    wb_ir     = s_ir;
    wb_npc    = s_npc;
    wb_data   = s_data;
    rd_addr_a = s_ra;
    rd_addr_b = s_rb;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic commit(input logic [15:0] ir, input logic [15:0] data, input logic [15:0] npc);
    s_valid = 1'b1;
    s_ir    = ir;
    s_data  = data;
    s_npc   = npc;
    cyc();
    s_valid = 1'b0;
  endtask

  // Monitor: compare every cycle, and pop a push record on each push_valid
  always @(negedge clk) begin
    exp_t  e;
    push_t p;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check16("rd_data_a", rd_data_a, e.rd_a);
      check16("rd_data_b", rd_data_b, e.rd_b);
      check128("regs_flat", regs_flat, e.regs);
      check1("wb_stall", wb_stall, e.stall);
      check1("push_valid", push_valid, e.pv);
      check1("int_ack", int_ack, e.ack);
      check1("wb_intf", wb_intf, e.intf);
      check1("wb_exc", wb_exc, e.exc);
    end
    if (push_valid) begin
      if (push_q.size() == 0) begin
        check1("push_unexpected", push_valid, 1'b0);
      end else begin
        p = push_q.pop_front();
        check16("push_addr", push_addr, p.addr);
        check1("push_sel", push_sel, p.sel);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; pause = 1'b0; irq = 1'b0; user_mode = 1'b0; wb_valid = 1'b0;
    wb_ir = '0; wb_npc = '0; wb_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    s_rst = 1'b0; s_pause = 1'b0; s_irq = 1'b0; s_um = 1'b0; s_valid = 1'b0;
    s_ir = '0; s_npc = '0; s_data = '0; s_ra = 3'd1; s_rb = 3'd6;
    idle(2);
    s_rst = 1'b1;

    // ADD R1, then LD R3 observed through the bypass
    commit(16'h1261, 16'h00AB, 16'h0);
    idle(1);
    s_ra = 3'd3;
    commit(16'h2600, 16'h1234, 16'h0);
    idle(1);
    // TRAP link write, WPS no write
    s_ra = 3'd7;
    commit(16'hF025, 16'hBEEF, 16'h3005);
    commit(16'h9E22, 16'hDEAD, 16'h0);
    idle(1);

    // R6 = 4000, then interrupt from user mode racing a commit to R2
    s_rb = 3'd2; s_ra = 3'd6;
    commit(16'h6C00, 16'h4000, 16'h0);
    s_um = 1'b1; s_irq = 1'b1; s_valid = 1'b1; s_ir = 16'h1400; s_data = 16'h7777;
    cyc();
    s_irq = 1'b0; s_valid = 1'b0;
    cyc();
    s_pause = 1'b1; idle(3);
    s_pause = 1'b0; idle(4);

    // Reserved opcode, then RTI back to user mode
    commit(16'hD000, 16'h1111, 16'h0);
    idle(2);
    commit(16'h8000, 16'h5555, 16'h0);
    idle(1);
    s_irq = 1'b1; cyc(); s_irq = 1'b0; idle(5);

    // Reset during PUSH_PC, then check restored SSP through a fresh entry
    s_irq = 1'b1; cyc(); s_irq = 1'b0;
    idle(2);
    s_rst = 1'b0; idle(2);
    s_rst = 1'b1;
    s_irq = 1'b1; cyc(); s_irq = 1'b0; idle(5);

    // Supervisor-mode entry with stack wrap below zero
    s_um = 1'b0;
    commit(16'h6C00, 16'h0001, 16'h0);
    s_irq = 1'b1; cyc(); s_irq = 1'b0; idle(5);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_ir    = 16'($urandom);
      if ($urandom_range(0, 9) == 0) s_ir = {4'h9, 3'($urandom), 3'b000, 6'h22};
      s_data  = 16'($urandom);
      s_npc   = 16'($urandom);
      s_irq   = ($urandom_range(0, 15) == 0);
      s_pause = ($urandom_range(0, 7) == 0);
      s_um    = 1'($urandom);
      s_ra    = 3'($urandom);
      s_rb    = 3'($urandom);
      cyc();
    end
    s_valid = 1'b0; s_irq = 1'b0; s_pause = 1'b0;
    idle(6);

    @(negedge clk);
    @(negedge clk);
    check16("scoreboard_drained", 16'(sb.size() + push_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
